ccff_chain_loader: RTL
======================

Name: ccff_chain_loader

Overview:
- Upstream feeder of the configuration-chain head (`ccff_head`) of the switch-block / connection-block / grid tile chain.
- Accepts bitstream bytes over a valid/ready stream and serializes them MSB-first onto `ccff_head`.
- Drives `ccff_shift_en`, which the fabric top uses to gate `prog_clk` into the chain, so the chain only advances when a real bit is presented.
- Counts exactly `CHAIN_LEN` bits, then reports done.

Parameters:
- CHAIN_LEN, 8, total configuration bits in the downstream chain (8 = four size-2 tapbuf muxes x 2 bits).
- DATA_W, 8, input word width in bits.
- CNT_W, $clog2(CHAIN_LEN+1), derived width of the bit counter; not overridden.

Ports:
- prog_clk  input  1  programming clock; all state updates on rising edge.
- prog_reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load; ignored unless state is IDLE or DONE.
- in_data  input  DATA_W  bitstream word; MSB is shifted first.
- in_valid  input  1  in_data valid.
- in_ready  output  1  word accepted on a cycle where in_valid and in_ready are both 1.
- ccff_head  output  1  serial bit to chain head; registered.
- ccff_shift_en  output  1  registered; 1 means the chain captures ccff_head on the next prog_clk edge.
- busy  output  1  high in LOAD or CHECK.
- done  output  1  level, high in DONE until the next start.
- crc_err  output  1  level, valid while done=1.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-load aborts immediately; chain contents are undefined and the host must restart.
- States: IDLE, LOAD, CHECK (feature only), DONE.
  - IDLE/DONE -> LOAD on start. Clears bit counter, shift register, done and crc_err.
  - LOAD -> DONE (or CHECK) in the cycle after the CHAIN_LEN-th bit is presented with ccff_shift_en=1.
  - CHECK -> DONE on acceptance of one trailer word.
- Word acceptance:
  - Accept at cycle t.
  - ccff_head = in_data[DATA_W-1] with ccff_shift_en=1 from t+1, one bit per cycle, in descending index order.
- in_ready in LOAD is 1 when the word register holds at most one unshifted bit and further bits are still required. This gives gapless back-to-back streaming.
- Stall: if no word is available when the word register empties, ccff_shift_en=0 and ccff_head holds its last value. The bit counter does not advance.
- Final partial word: when CHAIN_LEN mod DATA_W != 0, only the top (CHAIN_LEN mod DATA_W) bits of the last word are shifted. Its low bits are discarded, with ccff_shift_en=0 for them.
- Bit counter saturates at CHAIN_LEN. ccff_shift_en never exceeds CHAIN_LEN assertions per load.
- in_ready is 0 in IDLE and DONE. start while busy is ignored.

Optional Feature:
- Macro: CCFF_CHAIN_LOADER_CRC_EN.
- Defined:
  - A serial CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) is updated for every bit shifted with ccff_shift_en=1.
  - After CHAIN_LEN bits, the FSM enters CHECK. in_ready=1 there; the first accepted word's low 8 bits are compared against the CRC.
  - crc_err=1 on mismatch. DONE is entered either way; no bits are shifted in CHECK.
- Undefined: no CRC logic, no CHECK state, crc_err tied 0.

Decomposition:
- Package ccff_chain_loader_pkg holds:
  - state enum (IDLE, LOAD, CHECK, DONE),
  - CRC8_POLY = 8'h07,
  - CRC8_INIT = 8'h00.
- One sub-module, ccff_crc8_serial (inputs: clk, reset, clear, bit_en, bit_in; output: crc[7:0]). It is instantiated only under CCFF_CHAIN_LOADER_CRC_EN.

Test Plan:
- CHAIN_LEN=8: start, then 0xA5 -> ccff_head 1,0,1,0,0,1,0,1 on 8 consecutive cycles with ccff_shift_en=1; done=1 the cycle after; in_ready then stays 0.
- CHAIN_LEN=12: words 0xAB, 0xCF streamed -> 12 shift_en cycles, gapless, heads 1010_1011_1100; low nibble of 0xCF not shifted; done=1.
- CHAIN_LEN=16: in_valid dropped for 3 cycles between words -> ccff_shift_en=0 for exactly 3 cycles; ccff_head held; total shift_en count 16.
- Reset mid-load: prog_reset_n low after 5 bits of 0xA5 -> all outputs 0 immediately. start plus 0x3C then shifts a full 8 fresh bits 0,0,1,1,1,1,0,0.
- CRC_EN, CHAIN_LEN=8: 0xA5 then trailer 0x72 -> done=1, crc_err=0. Repeat with trailer 0x73 -> done=1, crc_err=1.
- start pulsed during LOAD -> ignored; bit count and head sequence unchanged.

Source files
------------

// File: rtl/ccff_chain_loader_pkg.sv
//==============================================================================
// Module   : ccff_chain_loader_pkg
// Brief    : Shared types and constants for the configuration-chain loader.
//            Optional feature macro: CCFF_CHAIN_LOADER_CRC_EN (CRC-8 trailer).
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package ccff_chain_loader_pkg;

    // Loader FSM states; CHECK is only reachable when the CRC trailer is built in
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // One MSB-first CRC-8 step: feed one serial bit into the running remainder
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ccff_crc8_serial.sv
//==============================================================================
// Module   : ccff_crc8_serial
// Brief    : Bit-serial CRC-8 (poly 0x07, init 0x00, no reflection, no final
//            XOR). Only instantiated when CCFF_CHAIN_LOADER_CRC_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ccff_crc8_serial
    import ccff_chain_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       bit_en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    // Next remainder: clear wins over an update so a new load starts clean
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC8_INIT;
        end else if (bit_en) begin
            crc_d = crc8_step(crc_q, bit_in);
        end
    end

    // Remainder register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= CRC8_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

`default_nettype wire

// File: rtl/ccff_chain_loader.sv
//==============================================================================
// Module   : ccff_chain_loader
// Brief    : Serializes bitstream words MSB-first onto the configuration chain
//            head, gating the chain via ccff_shift_en, for exactly CHAIN_LEN
//            bits. Optional feature macro: CCFF_CHAIN_LOADER_CRC_EN adds a
//            CRC-8 trailer check (CHECK state, crc_err output).
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ccff_chain_loader
    import ccff_chain_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int DATA_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    // Bit counter must be able to hold CHAIN_LEN itself (saturation value)
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    // Count of bits still waiting in the word register (max DATA_W-1)
    localparam int REM_W = $clog2(DATA_W + 1);

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;      // bits presented so far
    logic [REM_W-1:0]    rem_q,      rem_d;      // bits left in word register
    logic [DATA_W-1:0]   sreg_q,     sreg_d;     // pending bits, MSB next
    logic                head_q,     head_d;
    logic                shift_en_q, shift_en_d;
    logic [CNT_W-1:0]    bits_left;
    logic                ready_w;

`ifdef CCFF_CHAIN_LOADER_CRC_EN
    logic                crc_err_q,  crc_err_d;
    logic                crc_clear;
    logic [7:0]          crc_value;
    logic [7:0]          trailer;
`endif

    // Next-state, datapath and handshake decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        sreg_d     = sreg_q;
        head_d     = head_q;
        shift_en_d = shift_en_q;
        ready_w    = 1'b0;
        bits_left  = CNT_W'(CHAIN_LEN) - cnt_q;
`ifdef CCFF_CHAIN_LOADER_CRC_EN
        crc_err_d  = crc_err_q;
        crc_clear  = 1'b0;
        trailer    = 8'(in_data);
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = LOAD;
                    cnt_d      = '0;
                    rem_d      = '0;
                    sreg_d     = '0;
                    shift_en_d = 1'b0;
`ifdef CCFF_CHAIN_LOADER_CRC_EN
                    crc_err_d  = 1'b0;
                    crc_clear  = 1'b1;
`endif
                end
            end
            LOAD: begin
                // Ask for the next word while its predecessor's last bit is on
                // the head, so the following MSB lands on the very next cycle
                ready_w = (rem_q == '0) && (cnt_q < CNT_W'(CHAIN_LEN));
                if (cnt_q == CNT_W'(CHAIN_LEN)) begin
                    shift_en_d = 1'b0;
`ifdef CCFF_CHAIN_LOADER_CRC_EN
                    state_d    = CHECK;
`else
                    state_d    = DONE;
`endif
                end else if (rem_q != '0) begin
                    head_d     = sreg_q[DATA_W-1];
                    sreg_d     = sreg_q << 1;
                    rem_d      = rem_q - 1'b1;
                    shift_en_d = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end else if (in_valid) begin
                    head_d     = in_data[DATA_W-1];
                    sreg_d     = in_data << 1;
                    // A short final word keeps only the bits the chain still needs
                    if (32'(bits_left) >= DATA_W) begin
                        rem_d = REM_W'(DATA_W - 1);
                    end else begin
                        rem_d = REM_W'(bits_left - 1'b1);
                    end
                    shift_en_d = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end else begin
                    // Starved: freeze the chain, keep the head stable
                    shift_en_d = 1'b0;
                end
            end
`ifdef CCFF_CHAIN_LOADER_CRC_EN
            CHECK: begin
                ready_w = 1'b1;
                if (in_valid) begin
                    crc_err_d = (trailer != crc_value);
                    state_d   = DONE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any load in progress
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            sreg_q     <= '0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            sreg_q     <= sreg_d;
            head_q     <= head_d;
            shift_en_q <= shift_en_d;
        end
    end

`ifdef CCFF_CHAIN_LOADER_CRC_EN
    // Sticky trailer-check result, cleared by the next start
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            crc_err_q <= 1'b0;
        end else begin
            crc_err_q <= crc_err_d;
        end
    end

    // CRC tracks exactly the bits the chain captures
    ccff_crc8_serial u_crc (
        .clk    (prog_clk),
        .reset  (~prog_reset_n),
        .clear  (crc_clear),
        .bit_en (shift_en_q),
        .bit_in (head_q),
        .crc    (crc_value)
    );

    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif

    assign in_ready      = ready_w;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = (state_q == LOAD) || (state_q == CHECK);
    assign done          = (state_q == DONE);

endmodule

`default_nettype wire
